// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared definitions for the round-robin mux / demux channel fabric.
// Holds FSM state codes, channel count and select width so both ends of the
// link agree on the channel code carried on out_select.
package rr_mux_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Next channel in rotation order; wraps 3 -> 0.
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requesters.
// Ports:
//   req[3:0]  request vector
//   ptr[1:0]  highest-priority channel; priority falls off as ptr, ptr+1, ...
//   any       at least one request present
//   idx[1:0]  first requesting channel found scanning from ptr (mod 4)
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    logic [SEL_W-1:0] cand;
    any  = |req;
    idx  = ptr;
    cand = ptr;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_mux_4x1.sv
// rr_mux_4x1: four-channel round-robin mux with valid/ready handshakes and
// bounded bursts, feeding one registered output stream tagged with its source.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    enable; low blocks new input transfers only
//   in_valid/in_data      per-channel beats, channel k at in_data[k*WIDTH +: WIDTH]
//   in_ready              per-channel accept, at most one bit high (combinational)
//   out_valid/out_ready   output handshake
//   out_data/out_select   registered beat and its source channel
module rr_mux_4x1
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_select
);

  localparam int unsigned      CNT_W    = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_select_q, out_select_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               slot_rdy;
  logic               xfer;
  logic [WIDTH-1:0]   gnt_data;

  rr_pick4 u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state, handshake and output-register load logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_select_d = out_select_q;
    in_ready     = '0;
    slot_rdy     = 1'b0;
    xfer         = 1'b0;
    gnt_data     = '0;

    for (int k = 0; k < int'(NCH); k++) begin
      if (gnt_q == SEL_W'(k)) gnt_data = in_data[k*WIDTH +: WIDTH];
    end

    case (state_q)
      ST_IDLE: begin
        if (en && pick_any) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Accept only when the output register is empty or draining this cycle.
        slot_rdy        = en & (~out_valid_q | out_ready);
        in_ready[gnt_q] = slot_rdy;
        xfer            = slot_rdy & in_valid[gnt_q];
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        // Leave on burst limit, enable drop, or a drained channel.
        if ((xfer && (cnt_q == CNT_LAST)) || !en || (slot_rdy && !in_valid[gnt_q])) begin
          state_d = ST_IDLE;
          ptr_d   = sel_inc(gnt_q);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new beat overrides a simultaneous drain.
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = gnt_data;
      out_select_d = gnt_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_select_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_select_q <= out_select_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_select = out_select_q;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// tb_rr_mux_4x1: directed bench for rr_mux_4x1. Three instances (BURST 4, 2, 1)
// share stimulus; only the selected one is checked. Expected output beats are
// queued per test and popped by an independent monitor on each output handshake;
// the expected in_ready trace is checked cycle by cycle by the driver.
module tb_rr_mux_4x1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;

  logic [3:0] rdy_a, rdy_b, rdy_c;
  logic       ov_a, ov_b, ov_c;
  logic [7:0] od_a, od_b, od_c;
  logic [1:0] os_a, os_b, os_c;

  always #5 clk = ~clk;

  rr_mux_4x1 #(.WIDTH(8), .BURST(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_select(os_a));
  rr_mux_4x1 #(.WIDTH(8), .BURST(2)) u_b2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_select(os_b));
  rr_mux_4x1 #(.WIDTH(8), .BURST(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_c), .out_valid(ov_c), .out_ready(out_ready),
    .out_data(od_c), .out_select(os_c));

  int    n_tests = 0;
  int    n_fail  = 0;
  int    act     = 0;
  int    cyc     = 0;
  string tname   = "reset";

  logic [7:0] src0[$], src1[$], src2[$], src3[$];
  logic [3:0] exp_rdy[$];
  logic [9:0] sb[$];           // {select, data}

  logic [3:0] m_rdy;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  logic       s_valid;
  logic [7:0] s_data;
  logic [1:0] s_sel;

  always_comb begin
    case (act)
      1:       begin m_rdy = rdy_b; m_valid = ov_b; m_data = od_b; m_sel = os_b; end
      2:       begin m_rdy = rdy_c; m_valid = ov_c; m_data = od_c; m_sel = os_c; end
      default: begin m_rdy = rdy_a; m_valid = ov_a; m_data = od_a; m_sel = os_a; end
    endcase
  end

  task automatic chk(input string what, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s/c%0d %s: got %0h want %0h", tname, cyc, what, got, want);
    end
  endtask

  // Output monitor: every accepted output beat must be the next expected one.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && m_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s/c%0d beat: got sel=%0d data=%0h want none", tname, cyc, m_sel, m_data);
      end else begin
        e = sb.pop_front();
        chk("beat", 32'({m_sel, m_data}), 32'(e));
      end
    end
  end

  function automatic int qsize(input int k);
    case (k)
      0: return src0.size();
      1: return src1.size();
      2: return src2.size();
      default: return src3.size();
    endcase
  endfunction

  function automatic logic [7:0] qhead(input int k);
    case (k)
      0: return src0[0];
      1: return src1[0];
      2: return src2[0];
      default: return src3[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(src0.pop_front());
      1: void'(src1.pop_front());
      2: void'(src2.pop_front());
      default: void'(src3.pop_front());
    endcase
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic tick(input logic e, input logic o);
    logic [3:0] acc;
    en        = e;
    out_ready = o;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]      = (qsize(k) != 0);
      in_data[k*8 +: 8] = (qsize(k) != 0) ? qhead(k) : 8'h00;
    end
    #1;
    s_valid = m_valid;
    s_data  = m_data;
    s_sel   = m_sel;
    acc     = m_rdy & in_valid;
    if (exp_rdy.size() != 0) chk("in_ready", 32'(m_rdy), 32'(exp_rdy.pop_front()));
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (acc[k]) qpop(k);
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
  endtask

  task automatic clear_srcs();
    src0.delete(); src1.delete(); src2.delete(); src3.delete();
    exp_rdy.delete();
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic end_test();
    chk("all_beats_out", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic start(input string name, input int which);
    rst_n     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    clear_srcs();
    act   = which;
    tname = name;
    cyc   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values.
    #2;
    chk("rst_out_valid", 32'(m_valid), 32'd0);
    chk("rst_out_data", 32'(m_data), 32'd0);
    chk("rst_out_select", 32'(m_sel), 32'd0);
    chk("rst_in_ready", 32'(m_rdy), 32'd0);

    // Single channel, then ch3 vs ch2 shows ptr=3 after ch2 drained.
    start("single", 0);
    src2 = '{8'h11, 8'h22, 8'h33};
    sb = '{{2'd2, 8'h11}, {2'd2, 8'h22}, {2'd2, 8'h33}};
    exp_rdy = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    ticks(2);
    tick(1'b1, 1'b1);
    chk("lat_valid", 32'(s_valid), 32'd1);
    chk("lat_data", 32'(s_data), 32'h11);
    chk("lat_sel", 32'(s_sel), 32'd2);
    ticks(3);
    src2 = '{8'h44};
    src3 = '{8'h55};
    sb = '{{2'd3, 8'h55}, {2'd2, 8'h44}};
    exp_rdy = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h4, 4'h4, 4'h0};
    ticks(7);
    end_test();

    // Fairness with BURST=2 and all channels requesting.
    start("fair", 1);
    src0 = '{8'h01, 8'h02, 8'h03, 8'h04};
    src1 = '{8'h11, 8'h12};
    src2 = '{8'h21, 8'h22};
    src3 = '{8'h31, 8'h32};
    sb = '{{2'd0, 8'h01}, {2'd0, 8'h02}, {2'd1, 8'h11}, {2'd1, 8'h12}, {2'd2, 8'h21},
           {2'd2, 8'h22}, {2'd3, 8'h31}, {2'd3, 8'h32}, {2'd0, 8'h03}, {2'd0, 8'h04}};
    exp_rdy = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
    ticks(16);
    end_test();

    // Back-pressure on ch1.
    start("bp", 0);
    src1 = '{8'hA5, 8'h5A};
    sb = '{{2'd1, 8'hA5}, {2'd1, 8'h5A}};
    exp_rdy = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      chk("bp_hold_valid", 32'(s_valid), 32'd1);
      chk("bp_hold_data", 32'(s_data), 32'hA5);
    end
    tick(1'b1, 1'b1);
    chk("bp_release_data", 32'(s_data), 32'hA5);
    tick(1'b1, 1'b1);
    chk("bp_next_data", 32'(s_data), 32'h5A);
    ticks(1);
    end_test();

    // Enable drop mid-burst on ch3; ptr must become 0.
    start("en_drop", 0);
    src3 = '{8'h71, 8'h72, 8'h73, 8'h74};
    sb = '{{2'd3, 8'h71}, {2'd3, 8'h72}, {2'd0, 8'h01}, {2'd3, 8'h73}, {2'd3, 8'h74}};
    exp_rdy = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0,
                4'h8, 4'h8, 4'h8, 4'h0};
    ticks(3);
    tick(1'b0, 1'b1);
    chk("en_pending_valid", 32'(s_valid), 32'd1);
    chk("en_pending_data", 32'(s_data), 32'h72);
    tick(1'b0, 1'b1);
    chk("en_drained_valid", 32'(s_valid), 32'd0);
    src0 = '{8'h01};
    ticks(8);
    end_test();

    // BURST=1 with wrap from ptr=3.
    start("wrap_b1", 2);
    src2 = '{8'h22};
    sb = '{{2'd2, 8'h22}, {2'd3, 8'h31}, {2'd0, 8'h01}, {2'd3, 8'h32}, {2'd0, 8'h02}};
    exp_rdy = '{4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    ticks(2);
    src3 = '{8'h31, 8'h32};
    src0 = '{8'h01, 8'h02};
    ticks(9);
    end_test();

    // Reset mid-burst with a pending output beat; ptr returns to 0.
    start("mid_reset", 0);
    src1 = '{8'hB1};
    sb = '{{2'd1, 8'hB1}, {2'd2, 8'hC1}};
    exp_rdy = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4};
    ticks(3);
    src2 = '{8'hC1, 8'hC2, 8'hC3};
    ticks(3);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_data", 32'(m_data), 32'hC2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_select", 32'(m_sel), 32'd0);
    chk("mid_rst_in_ready", 32'(m_rdy), 32'd0);
    end_test();
    clear_srcs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    src0 = '{8'hD0};
    src3 = '{8'hD3};
    sb = '{{2'd0, 8'hD0}, {2'd3, 8'hD3}};
    exp_rdy = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h0};
    ticks(7);
    end_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
